// File: rtl/slab_compare_seq_if.sv
// Bus bundle for slab_compare_seq: job input handshake, shared comparator
// port and result handshake. The slave modport is the sequencer's view.
interface slab_compare_seq_if #(
    parameter int W = 26
);
    logic       in_valid;
    logic       in_ready;
    logic [W:0] tmin_x;
    logic [W:0] tmin_y;
    logic [W:0] tmin_z;
    logic [W:0] tmax_x;
    logic [W:0] tmax_y;
    logic [W:0] tmax_z;
    logic [W:0] cmp_a;
    logic [W:0] cmp_b;
    logic       cmp_issue;
    logic       cmp_greater;
    logic       out_valid;
    logic       out_ready;
    logic       hit;
    logic [W:0] tnear;
    logic [W:0] tfar;

    modport slave (
        input  in_valid, tmin_x, tmin_y, tmin_z, tmax_x, tmax_y, tmax_z,
        input  cmp_greater, out_ready,
        output in_ready, cmp_a, cmp_b, cmp_issue, out_valid, hit, tnear, tfar
    );

    modport master (
        output in_valid, tmin_x, tmin_y, tmin_z, tmax_x, tmax_y, tmax_z,
        output cmp_greater, out_ready,
        input  in_ready, cmp_a, cmp_b, cmp_issue, out_valid, hit, tnear, tfar
    );
endinterface

// File: rtl/slab_compare_seq.sv
// Ray-AABB slab test sequencer around one shared FP greater-than comparator.
// Five ordered compares form tnear = max(tmin), tfar = min(tmax) and
// hit = !(tnear > tfar). One compare is in flight at a time.
// Optional macro SLAB_BEHIND_REJECT_EN adds a sixth compare (0 > tfar) that
// rejects boxes lying wholly behind the ray origin.
module slab_compare_seq #(
    parameter int W       = 26,
    parameter int CMP_LAT = 3
) (
    input logic              clk,
    input logic              rst,
    slab_compare_seq_if.slave bus
);

    localparam int CW = $clog2(CMP_LAT + 1);

`ifdef SLAB_BEHIND_REJECT_EN
    localparam logic [2:0] LAST_STEP = 3'd5;
`else
    localparam logic [2:0] LAST_STEP = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [2:0]    step_q;
    logic [CW-1:0] cnt_q;

    logic [W:0] tmin_x_q, tmin_y_q, tmin_z_q;
    logic [W:0] tmax_x_q, tmax_y_q, tmax_z_q;

    logic       in_ready_q;
    logic       out_valid_q;
    logic       cmp_issue_q;
    logic [W:0] cmp_a_q, cmp_b_q;
    logic       hit_q;
    logic [W:0] tnear_q, tfar_q;

    logic       hit_d;
    logic [W:0] tnear_d, tfar_d;
    logic [W:0] nxt_a_d, nxt_b_d;

    logic g;
    assign g = bus.cmp_greater;

    // Step update for the compare just completed, plus operands of the next
    // step built from the freshly updated tnear/tfar so no idle cycle is needed.
    always_comb begin
        tnear_d = tnear_q;
        tfar_d  = tfar_q;
        hit_d   = hit_q;
        nxt_a_d = '0;
        nxt_b_d = '0;
        case (step_q)
            3'd0: begin
                tnear_d = g ? tmin_x_q : tmin_y_q;
                nxt_a_d = tnear_d;
                nxt_b_d = tmin_z_q;
            end
            3'd1: begin
                tnear_d = g ? tnear_q : tmin_z_q;
                nxt_a_d = tmax_x_q;
                nxt_b_d = tmax_y_q;
            end
            3'd2: begin
                tfar_d  = g ? tmax_y_q : tmax_x_q;
                nxt_a_d = tfar_d;
                nxt_b_d = tmax_z_q;
            end
            3'd3: begin
                tfar_d  = g ? tmax_z_q : tfar_q;
                nxt_a_d = tnear_q;
                nxt_b_d = tfar_d;
            end
            3'd4: begin
                hit_d = !g;
`ifdef SLAB_BEHIND_REJECT_EN
                nxt_a_d = '0;
                nxt_b_d = tfar_q;
`endif
            end
`ifdef SLAB_BEHIND_REJECT_EN
            3'd5: begin
                hit_d = hit_q && !g;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer FSM with registered handshake, comparator and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            tmin_x_q    <= '0;
            tmin_y_q    <= '0;
            tmin_z_q    <= '0;
            tmax_x_q    <= '0;
            tmax_y_q    <= '0;
            tmax_z_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cmp_issue_q <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            hit_q       <= 1'b0;
            tnear_q     <= '0;
            tfar_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        tmin_x_q    <= bus.tmin_x;
                        tmin_y_q    <= bus.tmin_y;
                        tmin_z_q    <= bus.tmin_z;
                        tmax_x_q    <= bus.tmax_x;
                        tmax_y_q    <= bus.tmax_y;
                        tmax_z_q    <= bus.tmax_z;
                        cmp_a_q     <= bus.tmin_x;
                        cmp_b_q     <= bus.tmin_y;
                        cmp_issue_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        step_q      <= '0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmp_issue_q <= 1'b0;
                    cnt_q       <= CW'(CMP_LAT);
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    // Counter hits zero at this edge: CMP_LAT cycles after issue.
                    if (cnt_q == CW'(1)) begin
                        tnear_q <= tnear_d;
                        tfar_q  <= tfar_d;
                        hit_q   <= hit_d;
                        if (step_q == LAST_STEP) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            step_q      <= step_q + 3'd1;
                            cmp_a_q     <= nxt_a_d;
                            cmp_b_q     <= nxt_b_d;
                            cmp_issue_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cmp_issue = cmp_issue_q;
    assign bus.cmp_a     = cmp_a_q;
    assign bus.cmp_b     = cmp_b_q;
    assign bus.hit       = hit_q;
    assign bus.tnear     = tnear_q;
    assign bus.tfar      = tfar_q;

endmodule

// File: tb/tb_slab_compare_seq.sv
// Directed bench for slab_compare_seq with a CMP_LAT-cycle comparator model.
// Honors SLAB_BEHIND_REJECT_EN for expected hit, latency and compare count.
module tb_slab_compare_seq;

    localparam int W       = 26;
    localparam int CMP_LAT = 3;

`ifdef SLAB_BEHIND_REJECT_EN
    localparam int EXP_LAT    = 25;
    localparam int EXP_ISSUES = 6;
    localparam logic EXP_BEHIND_HIT = 1'b0;
`else
    localparam int EXP_LAT    = 21;
    localparam int EXP_ISSUES = 5;
    localparam logic EXP_BEHIND_HIT = 1'b1;
`endif

    localparam logic [W:0] P1 = 27'h27FE000;
    localparam logic [W:0] P2 = 27'h2800000;
    localparam logic [W:0] P3 = 27'h2801000;
    localparam logic [W:0] P4 = 27'h2802000;
    localparam logic [W:0] N1 = 27'h37FE000;
    localparam logic [W:0] N2 = 27'h3800000;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    slab_compare_seq_if #(.W(W)) bus ();

    slab_compare_seq #(.W(W), .CMP_LAT(CMP_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ordering key for the FP format: zero, then signed magnitude.
    function automatic int fp_key(input logic [W:0] v);
        int m;
        m = int'({8'd0, v[23:0]}) + 1;
        if (v[26:25] == 2'b00) return 0;
        return v[24] ? -m : m;
    endfunction

    function automatic logic fp_gt(input logic [W:0] a, input logic [W:0] b);
        return fp_key(a) > fp_key(b);
    endfunction

    // Comparator model: true result only in the cycle CMP_LAT after issue,
    // the inverted result on the current operands at all other times.
    logic [CMP_LAT-1:0] pv;
    logic [CMP_LAT-1:0] pr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pr <= '0;
        end else begin
            pv <= {pv[CMP_LAT-2:0], bus.cmp_issue};
            pr <= {pr[CMP_LAT-2:0], fp_gt(bus.cmp_a, bus.cmp_b)};
        end
    end
    assign bus.cmp_greater = pv[CMP_LAT-1] ? pr[CMP_LAT-1] : ~fp_gt(bus.cmp_a, bus.cmp_b);

    // Issue monitor: counts strobes and records operands of every issue.
    int         issue_cnt;
    logic [W:0] issue_a [0:255];
    logic [W:0] issue_b [0:255];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= 0;
        end else if (bus.cmp_issue) begin
            issue_a[issue_cnt[7:0]] <= bus.cmp_a;
            issue_b[issue_cnt[7:0]] <= bus.cmp_b;
            issue_cnt <= issue_cnt + 1;
        end
    end

    // Drives one job from IDLE; returns at the negedge where out_valid first shows.
    task automatic run_job(input logic [W:0] ax, ay, az, bx, by, bz,
                           output int lat, output int n0);
        bit got;
        bus.tmin_x = ax; bus.tmin_y = ay; bus.tmin_z = az;
        bus.tmax_x = bx; bus.tmax_y = by; bus.tmax_z = bz;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n0  = issue_cnt;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!got) $display("FAIL job_done out_valid never rose within 100 cycles");
        else pass_cnt++;
        total_cnt++;
        if (issue_cnt - n0 !== EXP_ISSUES)
            $display("FAIL issue_count got=%0d exp=%0d", issue_cnt - n0, EXP_ISSUES);
        else pass_cnt++;
    endtask

    task automatic consume();
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.in_ready, bus.out_valid, bus.hit, bus.cmp_issue} !== 4'b1000)
            $display("FAIL reset_flags got=%b exp=1000",
                     {bus.in_ready, bus.out_valid, bus.hit, bus.cmp_issue});
        else pass_cnt++;
        total_cnt++;
        if ({bus.tnear, bus.tfar, bus.cmp_a, bus.cmp_b} !== '0)
            $display("FAIL reset_data tnear=%h tfar=%h a=%h b=%h exp=0",
                     bus.tnear, bus.tfar, bus.cmp_a, bus.cmp_b);
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, n0;
        logic [W:0] ea [0:4];
        logic [W:0] eb [0:4];
        ea[0] = P1; eb[0] = P2;
        ea[1] = P2; eb[1] = P1;
        ea[2] = P4; eb[2] = P3;
        ea[3] = P3; eb[3] = P4;
        ea[4] = P2; eb[4] = P3;
        run_job(P1, P2, P1, P4, P3, P4, lat, n0);
        total_cnt++;
        if (lat !== EXP_LAT) $display("FAIL basic_latency got=%0d exp=%0d", lat, EXP_LAT);
        else pass_cnt++;
        total_cnt++;
        if (bus.tnear !== P2) $display("FAIL basic_tnear got=%h exp=%h", bus.tnear, P2);
        else pass_cnt++;
        total_cnt++;
        if (bus.tfar !== P3) $display("FAIL basic_tfar got=%h exp=%h", bus.tfar, P3);
        else pass_cnt++;
        total_cnt++;
        if (bus.hit !== 1'b1) $display("FAIL basic_hit got=%b exp=1", bus.hit);
        else pass_cnt++;
        for (int s = 0; s < 5; s++) begin
            total_cnt++;
            if (issue_a[(n0 + s) % 256] !== ea[s] || issue_b[(n0 + s) % 256] !== eb[s])
                $display("FAIL basic_operands step=%0d got=%h,%h exp=%h,%h", s,
                         issue_a[(n0 + s) % 256], issue_b[(n0 + s) % 256], ea[s], eb[s]);
            else pass_cnt++;
        end
        consume();
    endtask

    task automatic test_miss();
        int lat, n0;
        run_job(P3, P1, P1, P4, P2, P4, lat, n0);
        total_cnt++;
        if ({bus.tnear, bus.tfar, bus.hit} !== {P3, P2, 1'b0})
            $display("FAIL miss_result got=%h/%h/%b exp=%h/%h/0", bus.tnear, bus.tfar, bus.hit, P3, P2);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_ties();
        int lat, n0;
        run_job(P2, P2, P2, P2, P2, P2, lat, n0);
        total_cnt++;
        if ({bus.tnear, bus.tfar, bus.hit} !== {P2, P2, 1'b1})
            $display("FAIL ties_result got=%h/%h/%b exp=%h/%h/1", bus.tnear, bus.tfar, bus.hit, P2, P2);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_handshake();
        int lat, n0;
        bit started;
        run_job(P1, P2, P1, P4, P3, P4, lat, n0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.out_valid, bus.in_ready, bus.cmp_issue, bus.hit, bus.tnear, bus.tfar}
                !== {1'b1, 1'b0, 1'b0, 1'b1, P2, P3})
                $display("FAIL hold_stable cycle=%0d got=%b%b%b%b %h %h exp=1001 %h %h", c,
                         bus.out_valid, bus.in_ready, bus.cmp_issue, bus.hit, bus.tnear, bus.tfar, P2, P3);
            else pass_cnt++;
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL ready_cycle_in_ready got=%b exp=0", bus.in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.cmp_issue} !== 3'b010)
            $display("FAIL after_ready got=%b exp=010", {bus.out_valid, bus.in_ready, bus.cmp_issue});
        else pass_cnt++;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.cmp_issue, bus.in_ready} !== 2'b10)
            $display("FAIL second_accept got=%b exp=10", {bus.cmp_issue, bus.in_ready});
        else pass_cnt++;
        started = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                started = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!started || bus.tnear !== P2 || bus.hit !== 1'b1)
            $display("FAIL second_job done=%b tnear=%h hit=%b exp=1 %h 1", started, bus.tnear, bus.hit, P2);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid();
        int lat, n0;
        bit found;
        bus.tmin_x = P1; bus.tmin_y = P2; bus.tmin_z = P1;
        bus.tmax_x = P4; bus.tmax_y = P3; bus.tmax_z = P4;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n0 = issue_cnt;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (issue_cnt - n0 == 3) begin
                found = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!found) $display("FAIL reach_step2 got=%0d issues exp=3", issue_cnt - n0);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.cmp_issue, bus.hit} !== 4'b0100)
            $display("FAIL midrst_flags got=%b exp=0100",
                     {bus.out_valid, bus.in_ready, bus.cmp_issue, bus.hit});
        else pass_cnt++;
        total_cnt++;
        if ({bus.tnear, bus.tfar, bus.cmp_a, bus.cmp_b} !== '0)
            $display("FAIL midrst_data tnear=%h tfar=%h a=%h b=%h exp=0",
                     bus.tnear, bus.tfar, bus.cmp_a, bus.cmp_b);
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        run_job(P3, P1, P1, P4, P2, P4, lat, n0);
        total_cnt++;
        if ({bus.tnear, bus.tfar, bus.hit} !== {P3, P2, 1'b0} || lat !== EXP_LAT)
            $display("FAIL post_reset_job got=%h/%h/%b lat=%0d exp=%h/%h/0 lat=%0d",
                     bus.tnear, bus.tfar, bus.hit, lat, P3, P2, EXP_LAT);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_behind();
        int lat, n0;
        run_job(N2, N2, N2, N1, N1, N1, lat, n0);
        total_cnt++;
        if ({bus.tnear, bus.tfar} !== {N2, N1})
            $display("FAIL behind_t got=%h/%h exp=%h/%h", bus.tnear, bus.tfar, N2, N1);
        else pass_cnt++;
        total_cnt++;
        if (bus.hit !== EXP_BEHIND_HIT) $display("FAIL behind_hit got=%b exp=%b", bus.hit, EXP_BEHIND_HIT);
        else pass_cnt++;
        total_cnt++;
        if (lat !== EXP_LAT) $display("FAIL behind_latency got=%0d exp=%0d", lat, EXP_LAT);
        else pass_cnt++;
        consume();
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.tmin_x = '0; bus.tmin_y = '0; bus.tmin_z = '0;
        bus.tmax_x = '0; bus.tmax_y = '0; bus.tmax_z = '0;
        test_reset();
        test_basic();
        test_miss();
        test_ties();
        test_handshake();
        test_reset_mid();
        test_behind();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
